// File: rtl/serial_frame_tx_if.sv
// Word-source handshake and serial-line status bundle for serial_frame_tx.
// The master modport is the word source; the slave modport is the transmitter.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_READY;
    logic              SDO;
    logic              BUSY;
    logic              TX_DONE;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY,
        input  SDO,
        input  BUSY,
        input  TX_DONE
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY,
        output SDO,
        output BUSY,
        output TX_DONE
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: idle-high line, start bit 0,
// DATA_W data bits, stop bit 1, every bit held CLKS_PER_BIT clocks.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LSB_FIRST    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    serial_frame_tx_if.slave   tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic             LSB_SEL  = (LSB_FIRST != 32'sd0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state_r,   state_s;
    logic [DATA_W-1:0] shift_r,   shift_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0]  cyc_cnt_r, cyc_cnt_s;
    logic              sdo_r,     sdo_s;
    logic              busy_r,    busy_s;
    logic              done_r,    done_s;
    logic [DATA_W-1:0] shift_adv_s;

    // The bit on the line always sits at the output end of the shift register.
    function automatic logic out_bit(input logic [DATA_W-1:0] v);
        if (LSB_SEL) begin
            return v[0];
        end else begin
            return v[DATA_W-1];
        end
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        if (LSB_SEL) begin
            return v >> 1'b1;
        end else begin
            return v << 1'b1;
        end
    endfunction

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        cyc_cnt_s   = cyc_cnt_r;
        sdo_s       = sdo_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        shift_adv_s = advance(shift_r);

        case (state_r)
            ST_IDLE: begin
                if (tx.TX_VALID) begin
                    // Start bit goes out on the accept edge itself.
                    state_s   = ST_START;
                    shift_s   = tx.TX_DATA;
                    bit_cnt_s = '0;
                    cyc_cnt_s = '0;
                    sdo_s     = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    sdo_s  = 1'b1;
                    busy_s = 1'b0;
                end
            end
            ST_START: begin
                if (cyc_cnt_r == CYC_LAST) begin
                    state_s   = ST_DATA;
                    cyc_cnt_s = '0;
                    bit_cnt_s = '0;
                    sdo_s     = out_bit(shift_r);
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
            ST_DATA: begin
                if (cyc_cnt_r == CYC_LAST) begin
                    cyc_cnt_s = '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s = ST_STOP;
                        sdo_s   = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                        shift_s   = shift_adv_s;
                        sdo_s     = out_bit(shift_adv_s);
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
            ST_STOP: begin
                if (cyc_cnt_r == CYC_LAST) begin
                    state_s   = ST_IDLE;
                    cyc_cnt_s = '0;
                    bit_cnt_s = '0;
                    sdo_s     = 1'b1;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                shift_s   = '0;
                bit_cnt_s = '0;
                cyc_cnt_s = '0;
                sdo_s     = 1'b1;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State and output registers; RST aborts any frame and discards its data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            cyc_cnt_r <= '0;
            sdo_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            cyc_cnt_r <= cyc_cnt_s;
            sdo_r     <= sdo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // READY is a pure state decode, so it never depends on TX_VALID.
    assign tx.TX_READY = (state_r == ST_IDLE);
    assign tx.SDO      = sdo_r;
    assign tx.BUSY     = busy_r;
    assign tx.TX_DONE  = done_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx across three parameter sets,
// compared cycle by cycle against a slot-based frame model.
module tb_serial_frame_tx;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_accept  = 0;
    int done_a       = 0;
    int done_b       = 0;
    int done_c       = 0;

    serial_frame_tx_if #(.DATA_W(8)) ia ();
    serial_frame_tx_if #(.DATA_W(8)) ib ();
    serial_frame_tx_if #(.DATA_W(1)) ic ();

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) dut_a (.CLK(CLK), .RST(RST), .tx(ia));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) dut_b (.CLK(CLK), .RST(RST), .tx(ib));
    serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .LSB_FIRST(1)) dut_c (.CLK(CLK), .RST(RST), .tx(ic));

    always #5 CLK = ~CLK;

    // Cycle stamp and TX_DONE pulse counters (old values read at the edge).
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ia.TX_DONE) done_a <= done_a + 1;
        if (ib.TX_DONE) done_b <= done_b + 1;
        if (ic.TX_DONE) done_c <= done_c + 1;
    end

    function automatic int p_dw(input int w);
        return (w == 2) ? 1 : 8;
    endfunction

    function automatic int p_cpb(input int w);
        return (w == 2) ? 1 : 4;
    endfunction

    function automatic int p_lsb(input int w);
        return (w == 1) ? 0 : 1;
    endfunction

    // Expected line level t cycles after the accept edge (t < frame length).
    function automatic logic model_sdo(input int dw, input int cpb, input int lsb,
                                       input logic [31:0] d, input int t);
        int slot;
        slot = t / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= dw) return (lsb != 0) ? d[slot - 1] : d[dw - slot];
        return 1'b1;
    endfunction

    // {SDO, BUSY, TX_READY, TX_DONE}
    function automatic logic [3:0] obs(input int w);
        case (w)
            0:       return {ia.SDO, ia.BUSY, ia.TX_READY, ia.TX_DONE};
            1:       return {ib.SDO, ib.BUSY, ib.TX_READY, ib.TX_DONE};
            2:       return {ic.SDO, ic.BUSY, ic.TX_READY, ic.TX_DONE};
            default: return 4'bxxxx;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [31:0] d);
        case (w)
            0: begin ia.TX_VALID = v; ia.TX_DATA = d[7:0]; end
            1: begin ib.TX_VALID = v; ib.TX_DATA = d[7:0]; end
            2: begin ic.TX_VALID = v; ic.TX_DATA = d[0:0]; end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests_run++;
        assert (o === e) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    // Send one word from a negedge where the DUT is idle; check every cycle up
    // to the TX_DONE cycle. Optionally change inputs at mut_t or reset at abort_t.
    task automatic send_frame(input int w, input logic [31:0] data, input int mut_t,
                              input logic mut_v, input logic [31:0] mut_d, input int abort_t);
        int dw, cpb, lsb, len;
        logic [3:0] o;
        logic [3:0] e;
        dw  = p_dw(w);
        cpb = p_cpb(w);
        lsb = p_lsb(w);
        len = (dw + 2) * cpb;
        o = obs(w);
        chk($sformatf("ready_pre w%0d", w), 32'(o[1]), 32'd1);
        drive(w, 1'b1, data);
        @(negedge CLK);
        last_accept = cyc;
        drive(w, 1'b0, data);
        for (int t = 0; t <= len; t++) begin
            if (t == abort_t) begin
                RST = 1'b1;
                @(negedge CLK);
                o = obs(w);
                chk($sformatf("abort w%0d t%0d", w, t), 32'(o), 32'(4'b1010));
                RST = 1'b0;
                return;
            end
            o = obs(w);
            e = (t == len) ? 4'b1011 : {model_sdo(dw, cpb, lsb, data, t), 3'b100};
            chk($sformatf("frame w%0d d%0h t%0d", w, data, t), 32'(o), 32'(e));
            if (t == mut_t) drive(w, mut_v, mut_d);
            if (t < len) @(negedge CLK);
        end
    endtask

    initial begin
        int a0;
        int d0;
        logic [3:0] o;

        drive(0, 1'b1, 32'h0000_00A5);
        drive(1, 1'b1, 32'h0000_0081);
        drive(2, 1'b1, 32'h0000_0001);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            for (int w = 0; w < 3; w++) begin
                o = obs(w);
                chk($sformatf("reset w%0d e%0d", w, i), 32'(o), 32'(4'b1010));
            end
        end
        drive(0, 1'b0, 32'd0);
        drive(1, 1'b0, 32'd0);
        drive(2, 1'b0, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        o = obs(0);
        chk("idle_after_reset", 32'(o), 32'(4'b1010));

        send_frame(0, 32'h0000_00A5, -1, 1'b0, 32'd0, -1);
        @(negedge CLK);
        chk("done_count_a5", 32'(done_a), 32'd1);
        for (int i = 0; i < 4; i++) send_frame(0, $urandom & 32'hFF, -1, 1'b0, 32'd0, -1);

        send_frame(1, 32'h0000_0081, -1, 1'b0, 32'd0, -1);
        for (int i = 0; i < 3; i++) send_frame(1, $urandom & 32'hFF, -1, 1'b0, 32'd0, -1);

        for (int i = 0; i < 6; i++) send_frame(2, $urandom & 32'h1, -1, 1'b0, 32'd0, -1);
        send_frame(2, 32'd1, -1, 1'b0, 32'd0, 1);
        @(negedge CLK);
        d0 = done_c;
        send_frame(2, 32'd0, -1, 1'b0, 32'd0, -1);
        @(negedge CLK);
        chk("done_count_c", 32'(done_c - d0), 32'd1);

        // Back-to-back: TX_VALID stays high from the first accept onward.
        @(negedge CLK);
        d0 = done_a;
        send_frame(0, 32'h0000_0000, 0, 1'b1, 32'h0000_00FF, -1);
        a0 = last_accept;
        send_frame(0, 32'h0000_00FF, -1, 1'b0, 32'd0, -1);
        chk("b2b_period", 32'(last_accept - a0), 32'd41);
        @(negedge CLK);
        chk("b2b_done_pulses", 32'(done_a - d0), 32'd2);

        // New data and TX_VALID presented mid-DATA are ignored until IDLE.
        send_frame(0, 32'h0000_003C, 8, 1'b1, 32'h0000_00FF, -1);
        drive(0, 1'b0, 32'd0);
        @(negedge CLK);
        o = obs(0);
        chk("idle_after_busy", 32'(o), 32'(4'b1010));

        // Reset during data bit 3, then a clean frame.
        d0 = done_a;
        send_frame(0, 32'h0000_00C3, -1, 1'b0, 32'd0, 4 * 4 + 1);
        @(negedge CLK);
        @(negedge CLK);
        chk("no_done_after_abort", 32'(done_a - d0), 32'd0);
        send_frame(0, 32'h0000_005A, -1, 1'b0, 32'd0, -1);
        @(negedge CLK);
        chk("done_after_5a", 32'(done_a - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
